systolic_feeder: RTL and testbench
==================================

SYSTOLIC_FEEDER -- requirements
Module: systolic_feeder

Interface
REQ-001 Parameter BITS_AB, default 8, SHALL set the signed element width, matching the MAC cell A/B operand width.
REQ-002 Parameter DIM, default 8, SHALL set the array dimension: DIM rows, DIM elements per row.
REQ-003 Port clk, input, 1: the single clock; all state SHALL change on its rising edge.
REQ-004 Port rst_n, input, 1: reset, asynchronous and active-low.
REQ-005 Port en, input, 1: stream advance enable, driven from the same signal as the array's MAC en.
REQ-006 Port WrEn, input, 1: write one row into the buffer.
REQ-007 Port Arow, input, clog2(DIM) bits: row index for the write.
REQ-008 Port Ain, input, DIM*BITS_AB bits: packed row data; element j occupies bits [j*BITS_AB +: BITS_AB].
REQ-009 Port start, input, 1: request a skewed stream of the buffered matrix.
REQ-010 Port Aout, output, DIM*BITS_AB bits: registered, skewed lane outputs; lane i occupies bits [i*BITS_AB +: BITS_AB] and feeds array row i.
REQ-011 Port valid, output, 1: registered; high while Aout carries stream data.
REQ-012 Port busy, output, 1: high whenever the state is STREAM.
REQ-013 Port done, output, 1: registered one-cycle pulse at stream completion.

Function
REQ-014 The block SHALL hold a DIM x DIM buffer A[i][j] of signed BITS_AB elements.
REQ-015 In IDLE, WrEn=1 SHALL write Ain into row Arow, element j into A[Arow][j], at the rising edge.
REQ-016 A write in STREAM SHALL be ignored, and the buffer SHALL remain unchanged.
REQ-017 An Arow value >= DIM SHALL be ignored.
REQ-018 The FSM SHALL have exactly two states, IDLE and STREAM.
REQ-019 IDLE SHALL go to STREAM on an edge with start=1, regardless of en, and the column counter cnt SHALL be cleared to 0.
REQ-020 start SHALL be ignored while in STREAM.
REQ-021 In STREAM, on each edge with en=1, every lane i SHALL load A[i][cnt-i] when 0 <= cnt-i <= DIM-1, and 0 otherwise.
REQ-022 On that same edge, valid SHALL be set to 1 and cnt SHALL increment.
REQ-023 In STREAM with en=0, Aout, valid and cnt SHALL all hold (stall).
REQ-024 The edge that processes cnt = 2*DIM-2 with en=1 SHALL be the last load; the edge after it SHALL return to IDLE and pulse done for one cycle.
REQ-025 A stream SHALL therefore deliver exactly 2*DIM-1 enabled output columns.
REQ-026 In IDLE, every edge SHALL drive Aout to 0, valid to 0, and done to 0, except the done pulse of REQ-024.
REQ-027 Latency: with start sampled at edge t and en held 1, column k SHALL be visible after edge t+1+k, and done SHALL be high after edge t+2*DIM.
REQ-028 start and WrEn in the same IDLE cycle SHALL both take effect, and the stream SHALL read the newly written row.
REQ-029 The buffer SHALL retain its contents across streams, so repeated starts replay the same matrix.
REQ-030 No arithmetic SHALL be applied: elements pass bit-exact, sign preserved.
REQ-031 Zero fill SHALL be used for lanes outside their diagonal window, so that the downstream MAC accumulates +0.

Reset
REQ-032 While rst_n=0, all of the following SHALL be asynchronously cleared: state to IDLE, cnt, Aout, valid, done, and every buffer element.
REQ-033 Reset asserted mid-stream SHALL abort immediately, with no done pulse and Aout=0 from the asserting edge of rst_n.
REQ-034 After rst_n deasserts, the first rising edge SHALL operate normally.

Verification
REQ-035 Write/stream: DIM=4, A[i][j]=16*i+j, start, en=1 -> lane outputs over the 7 columns SHALL be:
- lane 0: 00,01,02,03,0,0,0
- lane 3: 0,0,0,30,31,32,33
- valid high for 7 cycles, then a done pulse.
REQ-036 Stall: same as REQ-035 with en=0 for 2 cycles after column 2 -> Aout holds lane0=02, lane1=11, lane2=20, lane3=0 for 3 cycles, the sequence then resumes, and done is delayed 2 cycles.
REQ-037 Blocked write: WrEn with Arow=0, Ain all 0x7F during STREAM -> output unaffected, and a replay start outputs the original row 0.
REQ-038 Reset: rst_n low at column 3 -> Aout=0, valid=0 and busy=0 immediately, no done, and a following start outputs all zeros.
REQ-039 Same-cycle: in IDLE, WrEn with Arow=1, Ain elements all -1, plus start -> lane 1 outputs -1 (0xFF) in columns 1..4.
REQ-040 Sign: A[2][0]=-128 -> lane 2 outputs 0x80 at column 2.

Source files
------------

// File: rtl/systolic_feeder.sv
// Row buffer and skew generator for a DIM x DIM systolic array.
// Holds matrix A and streams it out diagonally, one enabled column per cycle.
module systolic_feeder #(
  parameter int BITS_AB = 8,
  parameter int DIM     = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     en,
  input  logic                     WrEn,
  input  logic [$clog2(DIM)-1:0]   Arow,
  input  logic [DIM*BITS_AB-1:0]   Ain,
  input  logic                     start,
  output logic [DIM*BITS_AB-1:0]   Aout,
  output logic                     valid,
  output logic                     busy,
  output logic                     done
);

  localparam int CW = $clog2(2*DIM);
  localparam logic [CW-1:0] CNT_END = CW'(2*DIM-1);

  typedef enum logic {IDLE, STREAM} state_t;

  state_t                       state_q, state_d;
  logic [CW-1:0]                cnt_q, cnt_d;
  logic [DIM*BITS_AB-1:0]       aout_q, aout_d;
  logic                         valid_q, valid_d;
  logic                         done_q, done_d;
  logic signed [BITS_AB-1:0]    mem_q [DIM][DIM];
  logic signed [BITS_AB-1:0]    mem_d [DIM][DIM];

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    aout_d  = '0;
    valid_d = 1'b0;
    done_d  = 1'b0;
    mem_d   = mem_q;

    unique case (state_q)
      IDLE: begin
        if (WrEn && (32'(Arow) < DIM)) begin
          for (int unsigned j = 0; j < DIM; j++) begin
            mem_d[Arow][j] = Ain[j*BITS_AB +: BITS_AB];
          end
        end
        if (start) begin
          state_d = STREAM;
          cnt_d   = '0;
        end
      end
      STREAM: begin
        // cnt only reaches CNT_END after the last enabled load, so this edge
        // closes the stream whatever en is doing.
        if (cnt_q == CNT_END) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end else if (en) begin
          for (int unsigned i = 0; i < DIM; i++) begin
            for (int unsigned j = 0; j < DIM; j++) begin
              if (32'(cnt_q) == i + j) begin
                aout_d[i*BITS_AB +: BITS_AB] = mem_q[i][j];
              end
            end
          end
          valid_d = 1'b1;
          cnt_d   = cnt_q + CW'(1);
        end else begin
          aout_d  = aout_q;
          valid_d = valid_q;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      aout_q  <= '0;
      valid_q <= 1'b0;
      done_q  <= 1'b0;
      for (int unsigned i = 0; i < DIM; i++) begin
        for (int unsigned j = 0; j < DIM; j++) begin
          mem_q[i][j] <= '0;
        end
      end
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      aout_q  <= aout_d;
      valid_q <= valid_d;
      done_q  <= done_d;
      mem_q   <= mem_d;
    end
  end

  assign Aout  = aout_q;
  assign valid = valid_q;
  assign done  = done_q;
  assign busy  = (state_q == STREAM);

endmodule

// File: tb/tb_systolic_feeder.sv
// Directed bench for systolic_feeder at DIM=4, BITS_AB=8.
module tb_systolic_feeder;

  localparam int BW = 8;
  localparam int D  = 4;

  logic            clk;
  logic            rst_n;
  logic            en;
  logic            WrEn;
  logic [1:0]      Arow;
  logic [D*BW-1:0] Ain;
  logic            start;
  logic [D*BW-1:0] Aout;
  logic            valid;
  logic            busy;
  logic            done;

  int checks = 0;
  int errors = 0;

  logic [7:0]  mem_m [D][D];
  logic [31:0] obs_col [7];

  systolic_feeder #(.BITS_AB(BW), .DIM(D)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (en),
    .WrEn  (WrEn),
    .Arow  (Arow),
    .Ain   (Ain),
    .start (start),
    .Aout  (Aout),
    .valid (valid),
    .busy  (busy),
    .done  (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog obs=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s obs=%h exp=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] exp_col(input int k);
    logic [31:0] r;
    r = '0;
    for (int i = 0; i < D; i++) begin
      if ((k - i) >= 0 && (k - i) < D) r[i*BW +: BW] = mem_m[i][k-i];
    end
    return r;
  endfunction

  task automatic wr_row(input int r, input logic [31:0] data);
    Arow = 2'(r);
    Ain  = data;
    WrEn = 1'b1;
    tick();
    WrEn = 1'b0;
    for (int j = 0; j < D; j++) mem_m[r][j] = data[j*BW +: BW];
  endtask

  // Full stream with optional stall after column stall_at and an optional
  // blocked write issued mid-stream; same_wr adds a row-1 write on the start edge.
  task automatic run_stream(input int stall_at, input int stall_len,
                            input bit blk, input bit same_wr);
    start = 1'b1;
    en    = 1'b1;
    if (same_wr) begin
      WrEn = 1'b1;
      Arow = 2'd1;
      Ain  = 32'hFFFF_FFFF;
      for (int j = 0; j < D; j++) mem_m[1][j] = 8'hFF;
    end
    tick();
    start = 1'b0;
    WrEn  = 1'b0;
    chk("start_busy", 32'(busy), 32'd1);
    chk("start_valid", 32'(valid), 32'd0);
    for (int k = 0; k < 7; k++) begin
      tick();
      obs_col[k] = Aout;
      chk($sformatf("col%0d", k), Aout, exp_col(k));
      chk($sformatf("col%0d_valid", k), 32'(valid), 32'd1);
      if (blk && k == 1) begin
        WrEn = 1'b1;
        Arow = 2'd0;
        Ain  = 32'h7F7F_7F7F;
      end
      if (blk && k == 2) WrEn = 1'b0;
      if (k == stall_at) begin
        en = 1'b0;
        for (int s = 0; s < stall_len; s++) begin
          tick();
          chk($sformatf("stall%0d", s), Aout, exp_col(k));
          chk($sformatf("stall%0d_valid", s), 32'(valid), 32'd1);
          chk($sformatf("stall%0d_done", s), 32'(done), 32'd0);
        end
        en = 1'b1;
      end
    end
    tick();
    chk("done_pulse", 32'(done), 32'd1);
    chk("done_valid", 32'(valid), 32'd0);
    chk("done_busy", 32'(busy), 32'd0);
    chk("done_aout", Aout, 32'd0);
    tick();
    chk("done_clear", 32'(done), 32'd0);
  endtask

  initial begin
    rst_n = 1'b0;
    en    = 1'b0;
    WrEn  = 1'b0;
    Arow  = '0;
    Ain   = '0;
    start = 1'b0;
    for (int i = 0; i < D; i++)
      for (int j = 0; j < D; j++) mem_m[i][j] = 8'h00;
    #1;
    chk("rst_aout", Aout, 32'd0);
    chk("rst_valid", 32'(valid), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    tick();
    tick();
    rst_n = 1'b1;
    tick();

    // A[i][j] = 16*i + j
    wr_row(0, 32'h0302_0100);
    wr_row(1, 32'h1312_1110);
    wr_row(2, 32'h2322_2120);
    wr_row(3, 32'h3332_3130);

    run_stream(-1, 0, 1'b0, 1'b0);
    chk("ws_col0", obs_col[0], 32'h0000_0000 | 32'h00);
    chk("ws_col3", obs_col[3], 32'h3021_1203);
    chk("ws_col6", obs_col[6], 32'h3300_0000);

    run_stream(2, 2, 1'b0, 1'b0);
    chk("stall_col2", obs_col[2], 32'h0020_1102);

    run_stream(-1, 0, 1'b1, 1'b0);
    run_stream(-1, 0, 1'b0, 1'b0);
    chk("replay_row0", {obs_col[3][7:0], obs_col[2][7:0], obs_col[1][7:0], obs_col[0][7:0]},
        32'h0302_0100);

    run_stream(-1, 0, 1'b0, 1'b1);
    chk("same_lane1", {obs_col[4][15:8], obs_col[3][15:8], obs_col[2][15:8], obs_col[1][15:8]},
        32'hFFFF_FFFF);
    chk("same_lane1_col5", 32'(obs_col[5][15:8]), 32'h00);

    wr_row(2, 32'h2322_2180);
    run_stream(-1, 0, 1'b0, 1'b0);
    chk("sign_lane2", 32'(obs_col[2][23:16]), 32'h80);

    // Abort mid-stream
    start = 1'b1;
    en    = 1'b1;
    tick();
    start = 1'b0;
    for (int k = 0; k < 4; k++) tick();
    chk("pre_rst_col3", Aout, exp_col(3));
    #2;
    rst_n = 1'b0;
    #1;
    chk("abort_aout", Aout, 32'd0);
    chk("abort_valid", 32'(valid), 32'd0);
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_done", 32'(done), 32'd0);
    for (int k = 0; k < 4; k++) begin
      tick();
      chk($sformatf("abort_nodone%0d", k), 32'(done), 32'd0);
    end
    rst_n = 1'b1;
    for (int i = 0; i < D; i++)
      for (int j = 0; j < D; j++) mem_m[i][j] = 8'h00;
    tick();
    run_stream(-1, 0, 1'b0, 1'b0);
    chk("zero_col3", obs_col[3], 32'h0000_0000);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
